// File: rtl/rom_loader_if.sv
// Byte-stream and fetch/status signals between the UART receiver/CPU (master)
// and the boot loader (slave).
interface rom_loader_if #(
  parameter int DEPTH_LOG2 = 12
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic [14:0]           pc;
  logic [15:0]           instruction;
  logic                  cpu_reset;
  logic                  load_done;
  logic                  load_error;
  logic [DEPTH_LOG2:0]   words_loaded;

  modport master (
    output rx_valid, rx_data, pc,
    input  instruction, cpu_reset, load_done, load_error, words_loaded
  );

  modport slave (
    input  rx_valid, rx_data, pc,
    output instruction, cpu_reset, load_done, load_error, words_loaded
  );
endinterface

// File: rtl/rom_loader.sv
// Boot loader: parses a framed, checksummed program image from the UART byte
// stream into instruction memory and holds the CPU in reset until it verifies.
module rom_loader #(
  parameter int         DEPTH_LOG2 = 12,
  parameter logic [7:0] SYNC       = 8'hA5
) (
  input logic        clock,
  input logic        reset,
  rom_loader_if.slave bus
);
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN_HI  = 3'd1;
  localparam logic [2:0] ST_LEN_LO  = 3'd2;
  localparam logic [2:0] ST_DATA_HI = 3'd3;
  localparam logic [2:0] ST_DATA_LO = 3'd4;
  localparam logic [2:0] ST_CHECK   = 3'd5;
  localparam logic [2:0] ST_RUN     = 3'd6;
  localparam logic [2:0] ST_ERROR   = 3'd7;

  localparam int          DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [16:0] MAX_LEN = 17'(DEPTH);

  logic [2:0]            state_q, state_d;
  logic [7:0]            len_hi_q, len_hi_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            data_hi_q, data_hi_d;
  logic [7:0]            sum_q, sum_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [DEPTH_LOG2:0]   words_q, words_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  load_done_q, load_done_d;
  logic                  load_error_q, load_error_d;
  logic                  mem_we;
  logic [15:0]           rx_len;
  logic [DEPTH_LOG2:0]   words_inc;
  logic                  unused_pc;
  logic [15:0]           mem [DEPTH];

  assign rx_len    = {len_hi_q, bus.rx_data};
  assign words_inc = words_q + (DEPTH_LOG2+1)'(1);

  always_comb begin
    state_d   = state_q;
    len_hi_d  = len_hi_q;
    len_d     = len_q;
    data_hi_d = data_hi_q;
    sum_d     = sum_q;
    addr_d    = addr_q;
    words_d   = words_q;
    mem_we    = 1'b0;
    if (bus.rx_valid) begin
      case (state_q)
        ST_IDLE: if (bus.rx_data == SYNC) state_d = ST_LEN_HI;
        ST_LEN_HI: begin
          len_hi_d = bus.rx_data;
          state_d  = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          len_d   = rx_len;
          addr_d  = '0;
          sum_d   = '0;
          words_d = '0;
          if ({1'b0, rx_len} > MAX_LEN) state_d = ST_ERROR;
          else if (rx_len == 16'd0)     state_d = ST_CHECK;
          else                          state_d = ST_DATA_HI;
        end
        ST_DATA_HI: begin
          data_hi_d = bus.rx_data;
          sum_d     = sum_q + bus.rx_data;
          state_d   = ST_DATA_LO;
        end
        ST_DATA_LO: begin
          mem_we  = 1'b1;
          sum_d   = sum_q + bus.rx_data;
          addr_d  = addr_q + DEPTH_LOG2'(1);
          words_d = words_inc;
          state_d = (32'(words_inc) == 32'(len_q)) ? ST_CHECK : ST_DATA_HI;
        end
        ST_CHECK: state_d = (bus.rx_data == sum_q) ? ST_RUN : ST_ERROR;
        ST_RUN, ST_ERROR: if (bus.rx_data == SYNC) state_d = ST_LEN_HI;
        default: state_d = ST_IDLE;
      endcase
    end
    // Status flags are registered from the next state so they move on the deciding edge.
    cpu_reset_d  = (state_d != ST_RUN);
    load_done_d  = (state_d == ST_RUN);
    load_error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_hi_q     <= '0;
      len_q        <= '0;
      data_hi_q    <= '0;
      sum_q        <= '0;
      addr_q       <= '0;
      words_q      <= '0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      len_q        <= len_d;
      data_hi_q    <= data_hi_d;
      sum_q        <= sum_d;
      addr_q       <= addr_d;
      words_q      <= words_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  // Memory is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[addr_q] <= {data_hi_q, bus.rx_data};
  end

  assign bus.instruction  = mem[bus.pc[DEPTH_LOG2-1:0]];
  assign unused_pc        = ^bus.pc;
  assign bus.cpu_reset    = cpu_reset_q;
  assign bus.load_done    = load_done_q;
  assign bus.load_error   = load_error_q;
  assign bus.words_loaded = words_q;
endmodule

// File: tb/tb_rom_loader.sv
// Randomized scoreboard bench for rom_loader: frames are built from a word list,
// expected outcomes queued, and a monitor checks status and memory on each completion.
module tb_rom_loader;
  localparam int         DL   = 12;
  localparam logic [7:0] SYNC = 8'hA5;

  typedef struct packed {
    logic        run;
    logic [DL:0] words;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  rom_loader_if #(.DEPTH_LOG2(DL)) bus ();

  rom_loader #(.DEPTH_LOG2(DL), .SYNC(SYNC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  int          events_expected = 0;
  int          events_checked = 0;
  exp_t        exp_q[$];
  logic [15:0] model_mem [1 << DL];
  int          model_hi = 0;
  logic [15:0] frame_words [64];
  logic        prev_done = 1'b0;
  logic        prev_err = 1'b0;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic int pick_gap(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clock);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    repeat (gap) begin
      @(negedge clock);
      bus.rx_valid = 1'b0;
    end
  endtask

  task automatic go_idle(input int n);
    repeat (n) begin
      @(negedge clock);
      bus.rx_valid = 1'b0;
    end
  endtask

  task automatic wait_checked();
    int t = 0;
    while (events_checked < events_expected && t < 2000) begin
      @(negedge clock);
      t++;
    end
    if (events_checked < events_expected) begin
      checks++;
      errors++;
      $display("[TB] FAIL completion_timeout: got %0d events expected %0d", events_checked, events_expected);
    end
  endtask

  // Sends a complete frame of frame_words[0..n-1] and queues its expected outcome.
  task automatic apply_stimulus(input int n, input bit bad, input int gmin, input int gmax, input bit probe_sync);
    int         sum = 0;
    logic [7:0] csum;
    exp_t       e;
    for (int i = 0; i < n; i++) sum += int'(frame_words[i][15:8]) + int'(frame_words[i][7:0]);
    csum = 8'(sum % 256);
    if (bad) csum = csum ^ 8'h01;
    e.run   = !bad;
    e.words = (DL+1)'(n);
    exp_q.push_back(e);
    events_expected++;
    if (probe_sync) begin
      check_output("reload_pre_done", 32'(bus.load_done), 32'd1);
      send_byte(SYNC, 1);
      check_output("reload_cpu_reset", 32'(bus.cpu_reset), 32'd1);
      check_output("reload_done_drop", 32'(bus.load_done), 32'd0);
    end else begin
      send_byte(SYNC, pick_gap(gmin, gmax));
    end
    send_byte(8'(n >> 8), pick_gap(gmin, gmax));
    send_byte(8'(n), pick_gap(gmin, gmax));
    for (int i = 0; i < n; i++) begin
      send_byte(frame_words[i][15:8], pick_gap(gmin, gmax));
      send_byte(frame_words[i][7:0], pick_gap(gmin, gmax));
      model_mem[i] = frame_words[i];
      if (i + 1 > model_hi) model_hi = i + 1;
    end
    send_byte(csum, pick_gap(gmin, gmax));
    go_idle(1);
    wait_checked();
  endtask

  task automatic oversize_frame();
    exp_t e;
    e.run   = 1'b0;
    e.words = '0;
    exp_q.push_back(e);
    events_expected++;
    send_byte(SYNC, 0);
    send_byte(8'h10, 0);
    send_byte(8'h01, 1);
    check_output("oversize_error", 32'(bus.load_error), 32'd1);
    check_output("oversize_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check_output("oversize_words", 32'(bus.words_loaded), 32'd0);
    wait_checked();
  endtask

  task automatic reset_mid_frame();
    for (int i = 0; i < 4; i++) frame_words[i] = 16'($urandom);
    send_byte(SYNC, 0);
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    for (int i = 0; i < 3; i++) begin
      send_byte(frame_words[i][15:8], 0);
      send_byte(frame_words[i][7:0], 0);
      model_mem[i] = frame_words[i];
      if (i + 1 > model_hi) model_hi = i + 1;
    end
    send_byte(frame_words[3][15:8], 1);
    check_output("midframe_words", 32'(bus.words_loaded), 32'd3);
    #1 reset = 1'b1;
    #1;
    check_output("async_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check_output("async_done", 32'(bus.load_done), 32'd0);
    check_output("async_error", 32'(bus.load_error), 32'd0);
    check_output("async_words", 32'(bus.words_loaded), 32'd0);
    #1 reset = 1'b0;
    go_idle(2);
  endtask

  // Monitor: a rising load_done or load_error marks the end of a frame.
  initial begin
    exp_t e;
    bit   ev;
    bus.pc = '0;
    forever begin
      @(negedge clock);
      ev = !reset && ((bus.load_done && !prev_done) || (bus.load_error && !prev_err));
      prev_done = bus.load_done;
      prev_err  = bus.load_error;
      if (ev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_completion: got done=%0b error=%0b expected none", bus.load_done, bus.load_error);
        end else begin
          e = exp_q.pop_front();
          check_output("load_done", 32'(bus.load_done), 32'(e.run));
          check_output("load_error", 32'(bus.load_error), 32'(!e.run));
          check_output("cpu_reset", 32'(bus.cpu_reset), 32'(!e.run));
          check_output("words_loaded", 32'(bus.words_loaded), 32'(e.words));
          for (int i = 0; i < model_hi; i++) begin
            bus.pc = 15'(i);
            #1;
            check_output($sformatf("mem[%0d]", i), 32'(bus.instruction), 32'(model_mem[i]));
          end
          bus.pc = '0;
        end
        events_checked++;
      end
    end
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #1 reset = 1'b1;
    #1;
    check_output("reset_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check_output("reset_done", 32'(bus.load_done), 32'd0);
    check_output("reset_error", 32'(bus.load_error), 32'd0);
    check_output("reset_words", 32'(bus.words_loaded), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 1);
    check_output("junk_ignored", 32'(bus.cpu_reset), 32'd1);

    frame_words[0] = 16'h1234;
    frame_words[1] = 16'hABCD;
    apply_stimulus(2, 1'b0, 0, 0, 1'b0);
    apply_stimulus(2, 1'b1, 0, 0, 1'b0);
    apply_stimulus(2, 1'b0, 1, 20, 1'b0);
    apply_stimulus(0, 1'b0, 0, 3, 1'b0);
    frame_words[0] = 16'h7FFF;
    apply_stimulus(1, 1'b0, 0, 2, 1'b1);
    oversize_frame();

    for (int f = 0; f < 8; f++) begin
      int  n;
      bit  bad;
      bit  b2b;
      n   = int'($urandom_range(16, 0));
      bad = ($urandom_range(3, 0) == 0);
      b2b = $urandom_range(1, 0) == 1;
      for (int i = 0; i < n; i++) frame_words[i] = 16'($urandom);
      if (b2b) apply_stimulus(n, bad, 0, 0, 1'b0);
      else     apply_stimulus(n, bad, 1, 20, 1'b0);
    end

    frame_words[0] = 16'h0001;
    apply_stimulus(1, 1'b0, 0, 1, 1'b0);
    reset_mid_frame();
    for (int i = 0; i < 4; i++) frame_words[i] = 16'($urandom);
    apply_stimulus(4, 1'b0, 0, 5, 1'b0);

    go_idle(4);
    check_output("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
